czono_op_scheduler: RTL
=======================

CZONO_OP_SCHEDULER -- requirements
Module: czono_op_scheduler

Interface
REQ-001 SHALL have parameter NMAX, default 10, meaning maximum state dimension.
REQ-002 SHALL have parameter NRMAX, default 10, meaning maximum rows of linear transform R.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning command queue entries (power of two).
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning maximum cycles waited for engine done.
REQ-005 SHALL have ports clk_i input 1 (clock) and rstn_i input 1 (reset), with one clock and an asynchronous, active-low reset.
REQ-006 SHALL have cmd_valid_i input 1 and cmd_ready_o output 1, forming the command handshake.
REQ-007 SHALL have cmd_op_i input 2, encoded 0=PLUS, 1=IMAGE, 2=INTERSECT, 3=reserved.
REQ-008 SHALL have cmd_tag_i input 4, an opaque command identifier.
REQ-009 SHALL have cmd_zn_i, cmd_wn_i and cmd_rn_i inputs of $clog2(NMAX)+1 bits, carrying Z.n, W/Y.n and R.n.
REQ-010 SHALL have cmd_rnr_i input $clog2(NRMAX)+1, carrying R.nr.
REQ-011 SHALL have plus_start_o, image_start_o and isect_start_o outputs 1, each a one-cycle engine launch.
REQ-012 SHALL have plus_done_i, image_done_i and isect_done_i inputs 1, the engine completion pulses.
REQ-013 SHALL have abort_o output 1, a one-cycle pulse to the active engine on timeout.
REQ-014 SHALL have sel_valid_o output 1 and sel_o output 2, giving BRAM-mux ownership and the owning engine (op encoding).
REQ-015 SHALL have rsp_valid_o output 1 and rsp_ready_i input 1, forming the response handshake.
REQ-016 SHALL have rsp_tag_o output 4 and rsp_status_o output 2, with status encoded 0=OK, 1=BADOP, 2=TIMEOUT, 3=DIMERR.
REQ-017 SHALL have busy_o output 1, high when the FSM is not IDLE or the queue is non-empty.

Function
REQ-018 SHALL accept a command when cmd_valid_i && cmd_ready_o at a rising edge; cmd_ready_o = !fifo_full.
REQ-019 SHALL queue commands FIFO-ordered; push and pop in the same cycle SHALL keep the count unchanged, and when full no push occurs.
REQ-020 SHALL implement the FSM states IDLE, CHECK, LAUNCH, WAIT and RESP.
REQ-021 IDLE SHALL pop and move to CHECK when the queue is non-empty, else stay in IDLE.
REQ-022 CHECK SHALL go to RESP with status BADOP when op==3.
REQ-023 CHECK SHALL go to RESP with status DIMERR on a dimension mismatch: PLUS zn!=wn; IMAGE rn!=zn; INTERSECT rn!=zn or rnr!=wn. Otherwise CHECK SHALL go to LAUNCH.
REQ-024 LAUNCH SHALL assert the selected *_start_o for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-025 WAIT SHALL go to RESP/OK when the selected done_i is sampled high.
REQ-026 WAIT SHALL assert abort_o for one cycle and go to RESP/TIMEOUT when the counter reaches TIMEOUT-1 without done; done and timeout in the same cycle SHALL resolve to OK.
REQ-027 Done inputs of non-selected engines, and any done asserted outside WAIT, SHALL be ignored.
REQ-028 sel_valid_o SHALL be high and sel_o stable in LAUNCH and WAIT only; sel_o SHALL be 0 otherwise.
REQ-029 RESP SHALL hold rsp_valid_o, rsp_tag_o and rsp_status_o stable until rsp_ready_i, then go to IDLE.
REQ-030 Latency: a command accepted at edge t into an empty, idle scheduler SHALL produce start high during cycle t+3.
REQ-031 The timeout counter SHALL be $clog2(TIMEOUT)+1 bits and saturate, never wrapping.

Reset
REQ-032 SHALL, on rstn_i low, asynchronously clear the queue and force IDLE.
REQ-033 SHALL hold every output at 0 during reset, except cmd_ready_o, which SHALL be 1 once rstn_i is high.
REQ-034 SHALL treat reset mid-operation as dropping all queued and in-flight commands with no response issued.

Structure
REQ-035 SHALL place op_e, status_e and state_e in shared package czono_pkg.
REQ-036 SHALL implement the queue as the sub-module czono_cmd_fifo (width 2+4+3*($clog2(NMAX)+1)+$clog2(NRMAX)+1, depth FIFO_DEPTH).

Verification
REQ-037 SHALL cover: PLUS, zn=wn=2, tag 5, plus_done_i 10 cycles after start -> plus_start_o one cycle at t+3, sel_o=0, response tag 5 status OK.
REQ-038 SHALL cover: INTERSECT, zn=2, wn=2, rn=2, rnr=3 -> no start pulse, status DIMERR; op=3 -> status BADOP.
REQ-039 SHALL cover: IMAGE with done never asserted, TIMEOUT=16 -> abort_o pulse 16 cycles after start, status TIMEOUT.
REQ-040 SHALL cover: 5 back-to-back commands with rsp_ready_i low -> cmd_ready_o low after the queue fills; responses then drain in order with tags preserved.
REQ-041 SHALL cover: rstn_i low while in WAIT -> all outputs 0 immediately, busy_o=0, no response after release.
REQ-042 SHALL cover: image_done_i pulsed while PLUS is active -> ignored, PLUS still completes OK on plus_done_i.

Source files
------------

// File: rtl/czono_pkg.sv
// Shared types for the constrained-zonotope op scheduler.
// Op, status and FSM state encodings plus the dimension check.
package czono_pkg;

  typedef enum logic [1:0] {
    OP_PLUS  = 2'd0,
    OP_IMAGE = 2'd1,
    OP_ISECT = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BADOP   = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_DIMERR  = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  // Operand shapes each engine requires before it may be launched.
  function automatic logic dim_err(
    input op_e         op,
    input int unsigned zn,
    input int unsigned wn,
    input int unsigned rn,
    input int unsigned rnr
  );
    logic err;
    err = 1'b0;
    case (op)
      OP_PLUS:  err = (zn != wn);
      OP_IMAGE: err = (rn != zn);
      OP_ISECT: err = (rn != zn) || (rnr != wn);
      default:  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/czono_cmd_fifo.sv
// Command queue for the op scheduler.
// Show-ahead read: rdata is the head entry whenever !empty.
module czono_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wdata,
  input  logic         rd_en,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/czono_op_scheduler.sv
// Queues zonotope op commands, validates shapes, launches one
// engine at a time, owns the BRAM mux and returns a status.
module czono_op_scheduler
  import czono_pkg::*;
#(
  parameter int NMAX       = 10,
  parameter int NRMAX      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_op_i,
  input  logic [3:0]             cmd_tag_i,
  input  logic [$clog2(NMAX):0]  cmd_zn_i,
  input  logic [$clog2(NMAX):0]  cmd_wn_i,
  input  logic [$clog2(NMAX):0]  cmd_rn_i,
  input  logic [$clog2(NRMAX):0] cmd_rnr_i,
  output logic                   plus_start_o,
  output logic                   image_start_o,
  output logic                   isect_start_o,
  input  logic                   plus_done_i,
  input  logic                   image_done_i,
  input  logic                   isect_done_i,
  output logic                   abort_o,
  output logic                   sel_valid_o,
  output logic [1:0]             sel_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [3:0]             rsp_tag_o,
  output logic [1:0]             rsp_status_o,
  output logic                   busy_o
);

  localparam int NW = $clog2(NMAX) + 1;
  localparam int RW = $clog2(NRMAX) + 1;
  localparam int FW = 2 + 4 + 3*NW + RW;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  state_e        state_q;
  state_e        state_d;
  status_e       status_q;
  status_e       status_d;
  logic [FW-1:0] cmd_q;
  logic [FW-1:0] wdata;
  logic [FW-1:0] rdata;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          launch;
  logic          timeout_hit;
  logic          done_sel;
  logic          owning;

  op_e           op;
  logic [3:0]    tag;
  logic [NW-1:0] zn;
  logic [NW-1:0] wn;
  logic [NW-1:0] rn;
  logic [RW-1:0] rnr;

  assign cmd_ready_o = rstn_i && !full;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign wdata       = {cmd_op_i, cmd_tag_i, cmd_zn_i,
                        cmd_wn_i, cmd_rn_i, cmd_rnr_i};

  czono_cmd_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .wr_en (push),
    .wdata (wdata),
    .rd_en (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign op  = op_e'(cmd_q[FW-1 -: 2]);
  assign tag = cmd_q[FW-3 -: 4];
  assign zn  = cmd_q[3*NW+RW-1 -: NW];
  assign wn  = cmd_q[2*NW+RW-1 -: NW];
  assign rn  = cmd_q[NW+RW-1 -: NW];
  assign rnr = cmd_q[RW-1:0];

  // Only the owning engine's done counts; others are ignored.
  always_comb begin
    done_sel = 1'b0;
    unique case (1'b1)
      (op == OP_PLUS):  done_sel = plus_done_i;
      (op == OP_IMAGE): done_sel = image_done_i;
      (op == OP_ISECT): done_sel = isect_done_i;
      default:          done_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    pop         = 1'b0;
    launch      = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op == OP_RSVD) begin
          status_d = ST_BADOP;
          state_d  = S_RESP;
        end else if (dim_err(op, 32'(zn), 32'(wn),
                             32'(rn), 32'(rnr))) begin
          status_d = ST_DIMERR;
          state_d  = S_RESP;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        launch  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done wins over a simultaneous timeout.
        if (done_sel) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (cnt_q == TLAST) begin
          timeout_hit = 1'b1;
          status_d    = ST_TIMEOUT;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      cmd_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      if (pop) cmd_q <= rdata;
      if (launch) begin
        cnt_q <= '0;
      end else if (state_q == S_WAIT && cnt_q != '1) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign owning = (state_q == S_LAUNCH) || (state_q == S_WAIT);

  assign plus_start_o  = launch && (op == OP_PLUS);
  assign image_start_o = launch && (op == OP_IMAGE);
  assign isect_start_o = launch && (op == OP_ISECT);
  assign abort_o       = timeout_hit;

  assign sel_valid_o  = owning;
  assign sel_o        = owning ? op : 2'd0;
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_tag_o    = rsp_valid_o ? tag : 4'd0;
  assign rsp_status_o = rsp_valid_o ? status_q : 2'd0;
  assign busy_o       = (state_q != S_IDLE) || !empty;

endmodule
